// File: rtl/cmd_pkg.sv
// Shared constants and types for the UART register-access protocol.
// Used by both the command serializer and the response collector.
package cmd_pkg;
  localparam logic [7:0] CMD_SYNC  = 8'hA5;
  localparam logic [7:0] RSP_SYNC  = 8'h5A;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam int         FRAME_LEN = 5;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_CHK_ERR  = 2'b01,
    ST_TIMEOUT  = 2'b10,
    ST_MISMATCH = 2'b11
  } rsp_status_t;

  // Body of a frame; the sync byte is implied by direction.
  typedef struct packed {
    logic [7:0] opcode;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] chk;
  } cmd_packet_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] op, input logic [7:0] addr,
                                           input logic [7:0] data);
    return op ^ addr ^ data;
  endfunction
endpackage

// File: rtl/rsp_frame_collector.sv
// Collects a 5-byte response frame: hunts for the sync byte, stores the body,
// and grades the frame on its final byte (checksum first, then echo compare).
module rsp_frame_collector
  import cmd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  input  logic [7:0]  exp_op,
  input  logic [7:0]  exp_addr,
  output logic        done,
  output logic [7:0]  rdata,
  output rsp_status_t status
);
  logic [2:0] idx;
  logic [7:0] op_q, addr_q, data_q;

  // Index falls back to zero whenever collection is disabled, so every
  // response wait starts with a fresh sync hunt.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx    <= '0;
      op_q   <= '0;
      addr_q <= '0;
      data_q <= '0;
    end else if (!en) begin
      idx <= '0;
    end else if (rx_byte_valid) begin
      case (idx)
        3'd0: if (rx_byte == RSP_SYNC) idx <= 3'd1;
        3'd1: begin op_q   <= rx_byte; idx <= 3'd2; end
        3'd2: begin addr_q <= rx_byte; idx <= 3'd3; end
        3'd3: begin data_q <= rx_byte; idx <= 3'd4; end
        default: idx <= '0;
      endcase
    end
  end

  assign done  = en && rx_byte_valid && (idx == 3'(FRAME_LEN - 1));
  assign rdata = data_q;

  always_comb begin
    status = ST_OK;
    if (rx_byte != frame_chk(op_q, addr_q, data_q))    status = ST_CHK_ERR;
    else if (op_q != exp_op || addr_q != exp_addr)     status = ST_MISMATCH;
  end
endmodule

// File: rtl/host_reg_master.sv
// Host-side register-access initiator: serializes one request into a command
// frame, then waits (bounded) for the matching response frame.
module host_reg_master
  import cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic [7:0] tx_byte,
  output logic       tx_byte_valid,
  input  logic       tx_byte_ready,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_valid,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic       busy
);
  localparam int            TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  state_t      state, state_n;
  cmd_packet_t pkt;
  logic [2:0]  idx;
  logic [TW-1:0] timer;
  rsp_status_t status_q, col_status;
  logic [7:0]  col_rdata, op_in, data_in;
  logic        col_done;

  assign op_in   = req_write ? OP_WRITE : OP_READ;
  assign data_in = req_write ? req_wdata : 8'h00;

  rsp_frame_collector u_col (
    .clk          (clk),
    .rst          (rst),
    .en           (state == WAIT_RSP),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .exp_op       (pkt.opcode),
    .exp_addr     (pkt.addr),
    .done         (col_done),
    .rdata        (col_rdata),
    .status       (col_status)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (req_valid && req_ready) state_n = SEND;
      SEND:     if (tx_byte_ready && idx == 3'(FRAME_LEN - 1)) state_n = WAIT_RSP;
      WAIT_RSP: if (col_done || timer == T_LAST) state_n = DONE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      pkt       <= '0;
      idx       <= '0;
      timer     <= '0;
      rsp_rdata <= '0;
      status_q  <= ST_OK;
    end else begin
      state     <= state_n;
      req_ready <= (state_n == IDLE);
      case (state)
        IDLE: if (req_valid && req_ready) begin
          pkt <= '{opcode: op_in, addr: req_addr, data: data_in,
                   chk: frame_chk(op_in, req_addr, data_in)};
          idx <= '0;
        end
        SEND: begin
          timer <= '0;
          if (tx_byte_ready) idx <= idx + 3'd1;
        end
        WAIT_RSP: begin
          timer <= timer + 1'b1;
          // A completing byte on the timeout cycle takes precedence.
          if (col_done) begin
            rsp_rdata <= col_rdata;
            status_q  <= col_status;
          end else if (timer == T_LAST) begin
            rsp_rdata <= 8'h00;
            status_q  <= ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    if (state == SEND) begin
      case (idx)
        3'd0:    tx_byte = CMD_SYNC;
        3'd1:    tx_byte = pkt.opcode;
        3'd2:    tx_byte = pkt.addr;
        3'd3:    tx_byte = pkt.data;
        3'd4:    tx_byte = pkt.chk;
        default: tx_byte = 8'h00;
      endcase
    end
  end

  assign tx_byte_valid = (state == SEND);
  assign rsp_valid     = (state == DONE);
  assign busy          = (state != IDLE);
  assign rsp_status    = status_q;
endmodule
